// File: rtl/cordic_rotator.sv
// cordic_rotator
//   Iterative rotation-mode CORDIC. Converts a polar pair (theta in degrees,
//   mag) into rectangular form: x_out = mag*cos(theta), y_out = mag*sin(theta).
//   One micro-rotation per clock. The FSM runs IDLE -> LOAD -> ROT (ITER
//   cycles) -> DONE -> IDLE. An out-of-range angle skips ROT and reports
//   range_err.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   start     request, sampled only in IDLE
//   theta     signed angle, degrees Q16.16, legal range [-180, +180]
//   mag       signed magnitude Q16.16, 0..2^30-1
//   busy      high from the accept edge until done
//   done      one-cycle pulse; results are valid from this cycle on
//   range_err theta of the last completed request was out of range
//   x_out     mag*cos(theta), Q16.16, held until the next done
//   y_out     mag*sin(theta), Q16.16, held until the next done

module cordic_rotator #(
  parameter int ITER = 16,
  parameter int KINV = 652032874
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] theta,
  input  logic signed [31:0] mag,
  output logic               busy,
  output logic               done,
  output logic               range_err,
  output logic signed [31:0] x_out,
  output logic signed [31:0] y_out
);

  typedef enum logic [1:0] {IDLE, LOAD, ROT, DONE} state_t;

  localparam logic signed [31:0] DEG180  = 32'sd11796480;
  localparam logic signed [31:0] DEG90   = 32'sd5898240;
  localparam logic signed [31:0] NDEG180 = -32'sd11796480;
  localparam logic signed [31:0] NDEG90  = -32'sd5898240;

  state_t             state, state_next;
  logic [4:0]         iter_cnt;
  logic signed [31:0] theta_q, mag_q;
  logic signed [33:0] x, y, z;
  logic               neg, err;
  logic               out_of_range;
  logic               dir;

  // arctan(2^-i) in Q16.16 degrees. Entries round to zero beyond i = 22.
  function automatic logic signed [33:0] atan_rom(input logic [4:0] idx);
    logic signed [31:0] v;
    case (idx)
      5'd0:  v = 32'sd2949120;
      5'd1:  v = 32'sd1740967;
      5'd2:  v = 32'sd919879;
      5'd3:  v = 32'sd466945;
      5'd4:  v = 32'sd234379;
      5'd5:  v = 32'sd117304;
      5'd6:  v = 32'sd58666;
      5'd7:  v = 32'sd29335;
      5'd8:  v = 32'sd14668;
      5'd9:  v = 32'sd7334;
      5'd10: v = 32'sd3667;
      5'd11: v = 32'sd1833;
      5'd12: v = 32'sd917;
      5'd13: v = 32'sd458;
      5'd14: v = 32'sd229;
      5'd15: v = 32'sd115;
      5'd16: v = 32'sd57;
      5'd17: v = 32'sd29;
      5'd18: v = 32'sd14;
      5'd19: v = 32'sd7;
      5'd20: v = 32'sd4;
      5'd21: v = 32'sd2;
      5'd22: v = 32'sd1;
      default: v = 32'sd0;
    endcase
    return 34'(v);
  endfunction

  assign out_of_range = (theta_q < NDEG180) || (theta_q > DEG180);

  // Rotate counter-clockwise while the residual angle is non-negative.
  assign dir = ~z[33];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = out_of_range ? DONE : ROT;
      ROT:     if (iter_cnt == 5'(ITER - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The datapath and output registers. theta/mag are captured at accept so
  // the inputs may change afterwards. Angles beyond +/-90 degrees lie outside
  // CORDIC convergence. They are folded by 180 degrees, and the result is
  // negated at the end.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      theta_q   <= '0;
      mag_q     <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
      iter_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            theta_q <= theta;
            mag_q   <= mag;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          err <= out_of_range;
          if (theta_q > DEG90) begin
            z   <= 34'(theta_q) - 34'(DEG180);
            neg <= 1'b1;
          end else if (theta_q < NDEG90) begin
            z   <= 34'(theta_q) + 34'(DEG180);
            neg <= 1'b1;
          end else begin
            z   <= 34'(theta_q);
            neg <= 1'b0;
          end
          x        <= 34'((64'(mag_q) * 64'(KINV)) >>> 30);
          y        <= '0;
          iter_cnt <= '0;
        end
        ROT: begin
          if (dir) begin
            x <= x - (y >>> iter_cnt);
            y <= y + (x >>> iter_cnt);
            z <= z - atan_rom(iter_cnt);
          end else begin
            x <= x + (y >>> iter_cnt);
            y <= y - (x >>> iter_cnt);
            z <= z + atan_rom(iter_cnt);
          end
          iter_cnt <= iter_cnt + 5'd1;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (err) begin
            x_out     <= '0;
            y_out     <= '0;
            range_err <= 1'b1;
          end else begin
            x_out     <= neg ? 32'(-x) : 32'(x);
            y_out     <= neg ? 32'(-y) : 32'(y);
            range_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
